serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on the clk rising edge.
REQ-005 The block SHALL have port A, input, WIDTH bits: the minuend, sampled only when start is accepted.
REQ-006 The block SHALL have port B, input, WIDTH bits: the subtrahend, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while the block is in state RUN.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse that is high while the block is in state DONE.
REQ-009 The block SHALL have port D, output, WIDTH bits: the registered difference A-B, modulo 2^WIDTH.
REQ-010 The block SHALL have port bout, output, 1 bit: registered borrow-out, high when A<B unsigned.
REQ-011 The block SHALL have port V, output, 1 bit: registered two's-complement overflow flag.
REQ-012 The block SHALL have port Z, output, 1 bit: registered zero flag, high when D equals 0.

Function
REQ-013 The block SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, when start=1 at a clock edge, the block SHALL capture A and B into shift registers, clear the borrow flop and the bit counter, and enter RUN.
REQ-015 In RUN, each clock edge SHALL process one bit, least significant bit first, as follows:
- d = a ^ b ^ br;
- next br = (~a & b) | (~(a ^ b) & br);
- d is shifted into the result register.
REQ-016 RUN SHALL last exactly WIDTH cycles, after which the state SHALL go to DONE.
REQ-017 On the edge that leaves RUN, the block SHALL update D, bout, V and Z together:
- bout = final borrow;
- V = (A[msb] ^ B[msb]) & (D[msb] ^ A[msb]), using the captured A and B;
- Z = (D == 0).
REQ-018 Latency: with start accepted at edge 0, done SHALL be high for the cycle between edge WIDTH and edge WIDTH+1, and busy SHALL be low during that cycle.
REQ-019 DONE SHALL return to IDLE after one cycle, unless start=1 in that cycle, in which case the block SHALL go directly to RUN with the new operands.
REQ-020 start asserted while in RUN SHALL be ignored: no operand capture, no restart, no error.
REQ-021 D, bout, V and Z SHALL hold their values from completion until the next completion or until reset; they SHALL NOT change during RUN.
REQ-022 Changes on A and B outside the accepting edge SHALL have no effect on the result.
REQ-023 A throughput of one result every WIDTH+1 cycles SHALL be sustained when start is held high.

Reset
REQ-024 When rst=1, the block SHALL immediately, without waiting for a clock edge:
- go to state IDLE;
- drive busy=0, done=0, D=0, bout=0, V=0 and Z=0;
- clear the shift registers, the counter and the borrow flop.
REQ-025 Reset asserted during RUN SHALL abort the operation with no done pulse, and no partial result SHALL be visible.
REQ-026 After rst is released, a start on the first clock edge SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 The bench SHALL cover the basic case: A=0x05, B=0x03, start for 1 cycle -> busy for 8 cycles, then done pulse; D=0x02, bout=0, V=0, Z=0.
REQ-028 The bench SHALL cover unsigned borrow: A=0x03, B=0x05 -> D=0xFE, bout=1, V=0, Z=0.
REQ-029 The bench SHALL cover signed overflow:
- A=0x80, B=0x01 -> D=0x7F, bout=0, V=1;
- A=0x7F, B=0xFF -> D=0x80, bout=1, V=1.
REQ-030 The bench SHALL cover zero, back-to-back and ignored start:
- A=0x5A, B=0x5A -> D=0x00, Z=1;
- start held high -> the next operation starts in the DONE cycle, with results every 9 cycles;
- start during RUN -> ignored.
REQ-031 The bench SHALL cover reset mid-operation: rst pulsed at RUN cycle 4 of 0x10-0x01 -> all outputs 0 at once, no done pulse; a later 0x10-0x01 run -> D=0x0F.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A-B one bit per cycle, LSB first.
// A start in IDLE or DONE captures the operands. RUN then lasts WIDTH cycles.
// DONE lasts one cycle, and its edge publishes D, bout, V and Z together.
// The published result holds until the next completion or until reset.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             V,
    output logic             Z
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             load_s;
    logic             last_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic             a_msb_r;
    logic             b_msb_r;

    logic             d_bit_s;
    logic             br_next_s;
    logic [WIDTH-1:0] res_next_s;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] d_r;
    logic             bout_r;
    logic             v_r;
    logic             z_r;

    // One-bit full-subtractor difference.
    function automatic logic sub_diff(input logic a, input logic b, input logic bi);
        return a ^ b ^ bi;
    endfunction

    // One-bit full-subtractor borrow-out.
    function automatic logic sub_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

    // Per-bit subtraction on the current LSBs; the difference bit enters the result at the MSB end.
    always_comb begin
        d_bit_s    = sub_diff(a_sh_r[0], b_sh_r[0], br_r);
        br_next_s  = sub_borrow(a_sh_r[0], b_sh_r[0], br_r);
        res_next_s = {d_bit_s, res_sh_r[WIDTH-1:1]};
    end

    // Next-state logic: accept start in IDLE or DONE, and leave RUN after WIDTH bits.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_next_s = DONE;
                    last_s       = 1'b1;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_next_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register; busy and done are registered from the next state so they track the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand shift registers, borrow and bit counter; results are published only on the last RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_sh_r <= '0;
            br_r     <= 1'b0;
            cnt_r    <= '0;
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            d_r      <= '0;
            bout_r   <= 1'b0;
            v_r      <= 1'b0;
            z_r      <= 1'b0;
        end else if (load_s) begin
            a_sh_r   <= A;
            b_sh_r   <= B;
            res_sh_r <= '0;
            br_r     <= 1'b0;
            cnt_r    <= '0;
            a_msb_r  <= A[WIDTH-1];
            b_msb_r  <= B[WIDTH-1];
        end else if (state_r == RUN) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_sh_r <= res_next_s;
            br_r     <= br_next_s;
            cnt_r    <= cnt_r + CW'(1);
            if (last_s) begin
                d_r    <= res_next_s;
                bout_r <= br_next_s;
                v_r    <= (a_msb_r ^ b_msb_r) & (res_next_s[WIDTH-1] ^ a_msb_r);
                z_r    <= (res_next_s == '0);
            end else begin
                d_r    <= d_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign D    = d_r;
    assign bout = bout_r;
    assign V    = v_r;
    assign Z    = z_r;

endmodule
